// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared definitions for the data-memory / MMIO bridge: access codes, peripheral
// offsets and timer control bit positions.
package dmem_mmio_bridge_pkg;

    // Load/store width codes reuse the core's funct3 encoding.
    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_TLOAD  = 8'h0C;
    localparam logic [7:0] OFF_TCOUNT = 8'h10;
    localparam logic [7:0] OFF_TCTRL  = 8'h14;
    localparam logic [7:0] OFF_TSTAT  = 8'h18;

    localparam int unsigned TCTRL_EN   = 0;
    localparam int unsigned TCTRL_AUTO = 1;
    localparam int unsigned TCTRL_IRQ  = 2;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} access_size_e;

    // Unknown codes fall back to a full word access.
    function automatic access_size_e access_size(input logic [2:0] mt);
        case (mt)
            MT_B, MT_BU: return SzByte;
            MT_H, MT_HU: return SzHalf;
            default:     return SzWord;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_bridge_mmio_timer.sv
// Down-counting peripheral timer: TLOAD/TCOUNT/TCTRL/TSTAT registers and its
// interrupt output.
module mmio_timer
    import dmem_mmio_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_tload,
    input  logic        wr_tctrl,
    input  logic        wr_tstat,
    input  logic [31:0] wdata,
    output logic [31:0] tload,
    output logic [31:0] tcount,
    output logic [2:0]  tctrl,
    output logic        tstat,
    output logic        irq
);

    logic [31:0] tload_q, tload_d;
    logic [31:0] tcount_q, tcount_d;
    logic [2:0]  tctrl_q, tctrl_d;
    logic        tstat_q, tstat_d;
    logic        expire;

    always_comb begin
        tload_d  = tload_q;
        tcount_d = tcount_q;
        tctrl_d  = tctrl_q;
        tstat_d  = tstat_q;
        expire   = 1'b0;
        if (tctrl_q[TCTRL_EN]) begin
            if (tcount_q > 32'd1) begin
                tcount_d = tcount_q - 32'd1;
            end else if (tcount_q == 32'd1) begin
                expire = 1'b1;
                if (tctrl_q[TCTRL_AUTO]) begin
                    tcount_d = tload_q;
                end else begin
                    tcount_d         = '0;
                    tctrl_d[TCTRL_EN] = 1'b0;
                end
            end
        end
        // Ordering gives expiry priority over W1C, and register writes priority
        // over the timer's own updates.
        if (wr_tstat && wdata[0]) tstat_d = 1'b0;
        if (expire)               tstat_d = 1'b1;
        if (wr_tload) begin
            tload_d  = wdata;
            tcount_d = wdata;
        end
        if (wr_tctrl) tctrl_d = wdata[2:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tload_q  <= '0;
            tcount_q <= '0;
            tctrl_q  <= '0;
            tstat_q  <= 1'b0;
        end else begin
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            tctrl_q  <= tctrl_d;
            tstat_q  <= tstat_d;
        end
    end

    assign tload  = tload_q;
    assign tcount = tcount_q;
    assign tctrl  = tctrl_q;
    assign tstat  = tstat_q;
    assign irq    = tstat_q & tctrl_q[TCTRL_IRQ];

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data-side bridge of the single-cycle core: word RAM plus a peripheral page,
// with byte/half lane steering and zero-wait load data.
module dmem_mmio_bridge
    import dmem_mmio_bridge_pkg::*;
#(
    parameter int unsigned DM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned SW_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_w,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       mem_type,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             irq
);

    localparam int unsigned AW = $clog2(DM_WORDS);

    logic [31:0]      ram [DM_WORDS];
    logic             is_mmio;
    logic [AW-1:0]    word_idx;
    logic [7:0]       mmio_off;
    logic             mmio_wr;
    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      cycle_q;
    logic [31:0]      tload, tcount;
    logic [2:0]       tctrl;
    logic             tstat;
    logic [31:0]      mmio_rdata, ld_word, ld_shift;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic             unused_addr;

    assign is_mmio     = addr[31:16] == MMIO_BASE[31:16];
    assign word_idx    = addr[AW+1:2];
    assign mmio_off    = {addr[7:2], 2'b00};
    assign mmio_wr     = mem_w && is_mmio;
    assign unused_addr = ^addr;

    // Stores: 1xx codes behave like their 0xx counterpart.
    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata;
        case (access_size({1'b0, mem_type[1:0]}))
            SzByte: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            SzHalf: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: st_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_w && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) ram[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (mmio_wr && mmio_off == OFF_LED) led_q <= wdata[LED_W-1:0];
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_q + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .wr_tload (mmio_wr && mmio_off == OFF_TLOAD),
        .wr_tctrl (mmio_wr && mmio_off == OFF_TCTRL),
        .wr_tstat (mmio_wr && mmio_off == OFF_TSTAT),
        .wdata    (wdata),
        .tload    (tload),
        .tcount   (tcount),
        .tctrl    (tctrl),
        .tstat    (tstat),
        .irq      (irq)
    );

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_LED:    mmio_rdata = 32'(led_q);
            OFF_SW:     mmio_rdata = 32'(sw_sync_q);
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_TLOAD:  mmio_rdata = tload;
            OFF_TCOUNT: mmio_rdata = tcount;
            OFF_TCTRL:  mmio_rdata = 32'(tctrl);
            OFF_TSTAT:  mmio_rdata = 32'(tstat);
            default:    mmio_rdata = '0;
        endcase
    end

    // Loads extract the addressed lane from RAM or peripheral word alike.
    always_comb begin
        ld_word  = is_mmio ? mmio_rdata : ram[word_idx];
        ld_shift = ld_word >> {addr[1:0], 3'b000};
        ld_b     = ld_shift[7:0];
        ld_h     = addr[1] ? ld_word[31:16] : ld_word[15:0];
        case (mem_type)
            MT_B:    rdata = {{24{ld_b[7]}}, ld_b};
            MT_BU:   rdata = {24'h0, ld_b};
            MT_H:    rdata = {{16{ld_h[15]}}, ld_h};
            MT_HU:   rdata = {16'h0, ld_h};
            default: rdata = ld_word;
        endcase
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: directed peripheral/timer scenarios
// plus randomized RAM traffic against a byte-array reference model.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] MMIO    = 32'hFFFF_0000;
    localparam logic [31:0] A_LED   = MMIO + 32'h00;
    localparam logic [31:0] A_SW    = MMIO + 32'h04;
    localparam logic [31:0] A_CYC   = MMIO + 32'h08;
    localparam logic [31:0] A_TLOAD = MMIO + 32'h0C;
    localparam logic [31:0] A_TCNT  = MMIO + 32'h10;
    localparam logic [31:0] A_TCTRL = MMIO + 32'h14;
    localparam logic [31:0] A_TSTAT = MMIO + 32'h18;

    logic        clk = 1'b0;
    logic        reset, mem_w, irq;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  mem_type;
    logic [15:0] sw_in, led_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [256];
    logic [31:0] rd_obs;

    always #5 clk = ~clk;

    dmem_mmio_bridge dut (
        .clk      (clk),
        .reset    (reset),
        .mem_w    (mem_w),
        .addr     (addr),
        .wdata    (wdata),
        .mem_type (mem_type),
        .rdata    (rdata),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One call = one rising edge; rdata is captured before that edge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] mt);
        mem_w    = mw;
        addr     = a;
        wdata    = d;
        mem_type = mt;
        #1;
        rd_obs = rdata;
        @(negedge clk);
        mem_w = 1'b0;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] mt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = ref_mem[a[7:0]];
        h = {ref_mem[{a[7:1], 1'b1}], ref_mem[{a[7:1], 1'b0}]};
        w = {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
             ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
        case (mt)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mt);
        case (mt[1:0])
            2'd0: ref_mem[a[7:0]] = d[7:0];
            2'd1: begin
                ref_mem[{a[7:1], 1'b0}] = d[7:0];
                ref_mem[{a[7:1], 1'b1}] = d[15:8];
            end
            default: for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = d[8*i +: 8];
        endcase
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] mt);
        step(1'b1, a, d, mt);
        if (a[31:16] != 16'hFFFF) ref_store(a, d, mt);
    endtask

    task automatic check_load(input string tag, input logic [31:0] a, input logic [2:0] mt,
                              input logic [31:0] exp);
        step(1'b0, a, 32'h0, mt);
        check(tag, rd_obs, exp);
    endtask

    // RAM address with random alias bits above the 4 KiB window, low 256 bytes only.
    function automatic logic [31:0] rand_ram_addr();
        logic [31:0] a;
        a = $urandom;
        a[11:8] = 4'h0;
        if (a[31:16] == 16'hFFFF) a[16] = 1'b0;
        return a;
    endfunction

    initial begin
        logic [31:0] c0, c1, a, d;
        logic [2:0]  mt;

        reset = 1'b1; mem_w = 1'b0; addr = '0; wdata = '0; mem_type = 3'd2; sw_in = '0;
        repeat (2) @(negedge clk);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        addr = A_TCNT; #1; check("rst_tcount", rdata, 32'h0);
        addr = A_CYC;  #1; check("rst_cycle", rdata, 32'h0);
        addr = A_TSTAT; #1; check("rst_tstat", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed RAM lane cases
        store(32'h10, 32'h1234_5678, 3'd2);
        check_load("lb_11", 32'h11, 3'd0, 32'h0000_0056);
        check_load("lh_12", 32'h12, 3'd1, 32'h0000_1234);
        store(32'h13, 32'h80, 3'd0);
        check_load("lb_13", 32'h13, 3'd0, 32'hFFFF_FF80);
        check_load("lbu_13", 32'h13, 3'd4, 32'h0000_0080);
        check_load("lw_10", 32'h10, 3'd2, 32'h8034_5678);

        // LED, unmapped offset, switch synchroniser, cycle counter
        store(A_LED, 32'h0000_A5A5, 3'd2);
        check("led_a5a5", 32'(led_out), 32'h0000_A5A5);
        check_load("mmio_1c", MMIO + 32'h1C, 3'd2, 32'h0);
        sw_in = 16'h00F0;
        check_load("sw_edge0", A_SW, 3'd2, 32'h0);
        check_load("sw_edge1", A_SW, 3'd2, 32'h0);
        check_load("sw_edge2", A_SW, 3'd2, 32'h0000_00F0);
        step(1'b0, A_CYC, 32'h0, 3'd2); c0 = rd_obs;
        repeat (5) step(1'b0, 32'h0, 32'h0, 3'd2);
        step(1'b0, A_CYC, 32'h0, 3'd2); c1 = rd_obs;
        check("cycle_delta", c1 - c0, 32'd6);

        // One-shot timer
        store(A_TLOAD, 32'd3, 3'd2);
        store(A_TCTRL, 32'h5, 3'd2);
        check_load("t1_cnt3", A_TCNT, 3'd2, 32'd3);
        check_load("t1_cnt2", A_TCNT, 3'd2, 32'd2);
        check("t1_irq_pre", 32'(irq), 32'h0);
        check_load("t1_cnt1", A_TCNT, 3'd2, 32'd1);
        check("t1_irq", 32'(irq), 32'h1);
        check_load("t1_stat", A_TSTAT, 3'd2, 32'h1);
        check_load("t1_cnt0", A_TCNT, 3'd2, 32'h0);
        check_load("t1_ctrl", A_TCTRL, 3'd2, 32'h4);
        store(A_TSTAT, 32'h1, 3'd2);
        check("t1_irq_clr", 32'(irq), 32'h0);

        // Auto-reload with period 2; W1C on an expiry edge must not clear
        store(A_TCTRL, 32'h7, 3'd2);
        store(A_TLOAD, 32'd2, 3'd2);
        check_load("t2_cnt2", A_TCNT, 3'd2, 32'd2);
        check_load("t2_stat0", A_TSTAT, 3'd2, 32'h0);
        check_load("t2_stat1", A_TSTAT, 3'd2, 32'h1);
        store(A_TSTAT, 32'h1, 3'd2);
        check_load("t2_w1c_keep", A_TSTAT, 3'd2, 32'h1);
        check_load("t2_cnt1", A_TCNT, 3'd2, 32'd1);
        store(A_TSTAT, 32'h1, 3'd2);
        check_load("t2_w1c_clr", A_TSTAT, 3'd2, 32'h0);
        check_load("t2_stat_again", A_TSTAT, 3'd2, 32'h1);
        check("t2_irq", 32'(irq), 32'h1);
        store(A_TCTRL, 32'h0, 3'd2);
        store(A_TSTAT, 32'h1, 3'd2);

        // TLOAD write coinciding with one-shot expiry
        store(A_TLOAD, 32'd2, 3'd2);
        store(A_TCTRL, 32'h1, 3'd2);
        step(1'b0, 32'h0, 32'h0, 3'd2);
        store(A_TLOAD, 32'd5, 3'd2);
        check_load("t3_cnt", A_TCNT, 3'd2, 32'd5);
        check_load("t3_stat", A_TSTAT, 3'd2, 32'h1);
        check_load("t3_ctrl", A_TCTRL, 3'd2, 32'h0);
        store(A_TSTAT, 32'h1, 3'd2);

        // TCTRL write coinciding with enable auto-clear
        store(A_TLOAD, 32'd1, 3'd2);
        store(A_TCTRL, 32'h1, 3'd2);
        store(A_TCTRL, 32'h3, 3'd2);
        check_load("t4_ctrl", A_TCTRL, 3'd2, 32'h3);
        check_load("t4_stat", A_TSTAT, 3'd2, 32'h1);
        check_load("t4_cnt", A_TCNT, 3'd2, 32'h0);
        store(A_TCTRL, 32'h0, 3'd2);
        store(A_TSTAT, 32'h1, 3'd2);

        // Sub-word stores to MMIO act as unshifted word writes
        repeat (6) begin
            d  = $urandom;
            mt = 3'($urandom_range(0, 7));
            store(A_LED | 32'($urandom_range(0, 3)), d, mt);
            check("led_subword", 32'(led_out), {16'h0, d[15:0]});
        end

        // Randomized RAM traffic
        for (int i = 0; i < 64; i++) store(rand_ram_addr() & 32'hFFFF_FF00 | 32'(i * 4),
                                           $urandom, 3'd2);
        repeat (300) begin
            a  = rand_ram_addr();
            mt = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                store(a, $urandom, mt);
            end else begin
                check_load("ram_rand", a, mt, ref_load(a, mt));
            end
        end

        // Reset asserted while the timer is counting
        store(A_LED, 32'h0000_3C3C, 3'd2);
        store(A_TLOAD, 32'd2, 3'd2);
        store(A_TCTRL, 32'h7, 3'd2);
        repeat (3) step(1'b0, 32'h0, 32'h0, 3'd2);
        check("pre_rst_irq", 32'(irq), 32'h1);
        reset = 1'b1;
        addr  = A_TCNT;
        #1;
        check("mid_rst_tcount", rdata, 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_led", 32'(led_out), 32'h0);
        addr = A_CYC; #1;
        check("mid_rst_cycle", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_load("post_rst_ctrl", A_TCTRL, 3'd2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
